mdr_mem_unit: RTL
=================

MDR_MEM_UNIT -- requirements
Module: mdr_mem_unit

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum cycles the unit waits for mem_ready per transaction (legal range 2..255).
REQ-002 Port: clock  in  1  system clock; all state changes on the rising edge.
REQ-003 Port: clear  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port: BusMuxOut  in  32  shared bus value; source for MAR and for bus-sourced MDR loads.
REQ-005 Port: MARin  in  1  load MAR from BusMuxOut[8:0].
REQ-006 Port: MDRin  in  1  MDR load enable.
REQ-007 Port: Read  in  1  MDR source select with MDRin: 0 = bus, 1 = memory read transaction.
REQ-008 Port: Write  in  1  start memory write of MDR to MAR.
REQ-009 Port: mem_rdata  in  32  memory read data, valid when mem_ready=1.
REQ-010 Port: mem_ready  in  1  memory completion strobe.
REQ-011 Port: BusMuxInMDR  out  32  MDR contents, driven to the bus mux.
REQ-012 Port: mem_addr  out  9  MAR contents.
REQ-013 Port: mem_wdata  out  32  MDR contents during writes, 0 otherwise.
REQ-014 Port: mem_rd  out  1  read request, level.
REQ-015 Port: mem_wr  out  1  write request, level.
REQ-016 Port: busy  out  1  high whenever state is not IDLE.
REQ-017 Port: done  out  1  single-cycle pulse, transaction completed.
REQ-018 Port: err  out  1  sticky timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, READ and WRITE; outputs mem_rd, mem_wr and busy SHALL be Moore outputs (mem_rd=1 only in READ, mem_wr=1 only in WRITE).
REQ-020 In IDLE, MARin=1 SHALL load MAR <= BusMuxOut[8:0] at the edge.
REQ-021 In IDLE, MDRin=1 and Read=0 SHALL load MDR <= BusMuxOut at the edge, without a state change and without a done pulse.
REQ-022 In IDLE, MDRin=1 and Read=1 SHALL move the FSM to READ at the edge.
REQ-023 In IDLE, Write=1 without a read start SHALL move the FSM to WRITE at the edge.
REQ-024 Simultaneous read start and Write SHALL start the read only; the write is dropped.
REQ-025 Simultaneous MARin and a transaction start SHALL load MAR, and the transaction SHALL use the new MAR value.
REQ-026 In READ or WRITE, MARin, MDRin and Write SHALL be ignored; MAR and MDR are stable except as REQ-028 specifies.
REQ-027 A 8-bit wait counter SHALL clear on entry to READ or WRITE and increment each edge in READ or WRITE at which mem_ready=0.
REQ-028 In READ, mem_ready=1 at an edge SHALL load MDR <= mem_rdata and return the FSM to IDLE.
REQ-029 In WRITE, mem_ready=1 at an edge SHALL return the FSM to IDLE; MDR is unchanged.
REQ-030 done SHALL be 1 in exactly the cycle following the completing edge of REQ-028 or REQ-029, and 0 otherwise.
REQ-031 If mem_ready=0 at the edge where the counter equals TIMEOUT-1, the unit SHALL set err=1 and return to IDLE, with MDR unchanged and no done pulse.
REQ-032 Minimum latency SHALL be: start edge N, mem_rd/mem_wr high in cycle N+1, mem_ready high at edge N+1, done high in cycle N+2.
REQ-033 err SHALL remain 1 until clear; new transactions SHALL still be accepted while err=1.
REQ-034 mem_rd and mem_wr SHALL never be 1 in the same cycle.
REQ-035 mem_ready asserted while in IDLE SHALL be ignored.

Reset
REQ-036 clear=1 at an edge SHALL force state to IDLE and zero MAR, MDR and the counter, giving BusMuxInMDR=0, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0, busy=0, done=0 and err=0.
REQ-037 clear SHALL take priority over every other input, including mid-transaction; an aborted transaction SHALL produce no done pulse and no MDR update.

Verification
REQ-038 Bus load: BusMuxOut=0xDEADBEEF, MDRin=1, Read=0 for one edge -> BusMuxInMDR=0xDEADBEEF next cycle, busy=0, done=0.
REQ-039 Read: MAR=0x05A, MDRin=1, Read=1; mem_ready=1 with mem_rdata=0x12345678 after 3 wait cycles -> mem_rd high 4 cycles with mem_addr=0x05A, then BusMuxInMDR=0x12345678 and a 1-cycle done.
REQ-040 Write: MDR=0xCAFEF00D, Write=1; mem_ready after 1 wait cycle -> mem_wr high 2 cycles with mem_wdata=0xCAFEF00D, then done pulse; MDR unchanged.
REQ-041 Timeout: TIMEOUT=15, read started, mem_ready held 0 -> mem_rd high exactly 15 cycles, then err=1, busy=0, no done; a subsequent read completes normally while err stays 1.
REQ-042 Conflicts: MDRin=1, Read=1, Write=1 and MARin=1 with BusMuxOut=0x1FF -> READ entered, mem_addr=0x1FF, mem_wr never asserts; MDRin pulsed during READ has no effect.
REQ-043 Reset mid-read: clear=1 in the 2nd wait cycle -> next cycle all outputs 0, no done, MDR=0.

Source files
------------

// File: rtl/mdr_mem_unit.sv
// MAR/MDR register pair with a memory read/write handshake FSM.
// Each transaction is bounded by a wait-cycle timeout that raises a sticky error flag.
module mdr_mem_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] BusMuxOut,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] BusMuxInMDR,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // The last wait count that is still tolerated before giving up on the memory.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [8:0]  mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_rd_q, mem_wr_q, busy_q;
    logic [31:0] wdata_q;

    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (MARin) begin
                    mar_d = BusMuxOut[8:0];
                end
                // A read start wins over a simultaneous write request.
                if (MDRin && Read) begin
                    state_d = ST_READ;
                end else begin
                    if (MDRin) begin
                        mdr_d = BusMuxOut;
                    end
                    if (Write) begin
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_READ, ST_WRITE: begin
                if (mem_ready) begin
                    if (state_q == ST_READ) begin
                        mdr_d = mem_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they remain pure Moore outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            mar_q    <= '0;
            mdr_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            mem_rd_q <= (state_d == ST_READ);
            mem_wr_q <= (state_d == ST_WRITE);
            busy_q   <= (state_d != ST_IDLE);
            wdata_q  <= (state_d == ST_WRITE) ? mdr_d : 32'h0;
        end
    end

    assign BusMuxInMDR = mdr_q;
    assign mem_addr    = mar_q;
    assign mem_wdata   = wdata_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
